// File: rtl/keccak_chi_step.sv
// Keccak-f[1600] chi step: a non-linear row mapping over the full 5x5x64
// state. The output is registered once, and a valid flag travels with it.
// The state dimensions come from keccak_pkg, which is defined in this file.

package keccak_pkg;
    localparam int ROW_SIZE  = 5;   // x positions
    localparam int COL_SIZE  = 5;   // y positions
    localparam int LANE_SIZE = 64;  // z bits per lane
endpackage

module keccak_chi_step
    import keccak_pkg::*;
(
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_in,
    output logic                                         out_valid,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_out
);

    localparam int STATE_W = ROW_SIZE * COL_SIZE * LANE_SIZE;

    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] chi_s;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_out_r;
    logic                                             valid_r;

    // The mapping is bitwise along each lane, so every lane is built from
    // three lanes of the same row. The x neighbours wrap modulo ROW_SIZE:
    // x=3 uses lanes 4 and 0, and x=4 uses lanes 0 and 1.
    for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_x
        for (genvar gy = 0; gy < COL_SIZE; gy++) begin : g_y
            assign chi_s[gx][gy] = state_array_in[gx][gy] ^
                                   (~state_array_in[(gx + 1) % ROW_SIZE][gy] &
                                     state_array_in[(gx + 2) % ROW_SIZE][gy]);
        end
    end

    // Output register. Reset takes priority and clears any in-flight result.
    // The register loads a new state only when in_valid is high, and holds
    // its value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_out_r <= {STATE_W{1'b0}};
            valid_r     <= 1'b0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                state_out_r <= chi_s;
            end else begin
                state_out_r <= state_out_r;
            end
        end
    end

    assign state_array_out = state_out_r;
    assign out_valid       = valid_r;

endmodule

// File: tb/tb_keccak_chi_step.sv
// Self-checking bench for keccak_chi_step. It drives directed and random
// stimulus and checks the DUT against an array-based chi reference model.

module tb_keccak_chi_step;

    typedef logic [63:0] lane_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic [4:0][4:0][63:0]   state_in;
    logic                    out_valid;
    logic [4:0][4:0][63:0]   state_out;

    lane_t cur_st [5][5];   // state the bench is about to apply
    lane_t exp_st [5][5];   // expected contents of the output register
    logic  exp_valid;

    int n_compared;
    int n_mismatched;

    keccak_chi_step dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .state_array_in  (state_in),
        .out_valid       (out_valid),
        .state_array_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input lane_t observed, input lane_t expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                check($sformatf("%s_lane[%0d][%0d]", tag, x, y), state_out[x][y], exp_st[x][y]);
            end
        end
        check({tag, "_valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
    endtask

    // Apply cur_st with the given rst/in_valid for one edge, advance the
    // reference model, and compare shortly after the edge.
    task automatic step(input logic r, input logic v, input string tag);
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                state_in[x][y] = cur_st[x][y];
            end
        end
        rst      = r;
        in_valid = v;
        @(posedge clk);
        if (r) begin
            for (int x = 0; x < 5; x++) begin
                for (int y = 0; y < 5; y++) begin
                    exp_st[x][y] = 64'd0;
                end
            end
            exp_valid = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                for (int x = 0; x < 5; x++) begin
                    for (int y = 0; y < 5; y++) begin
                        exp_st[x][y] = cur_st[x][y] ^
                                       (~cur_st[(x + 1) % 5][y] & cur_st[(x + 2) % 5][y]);
                    end
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic fill_random();
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                cur_st[x][y] = {$urandom(), $urandom()};
            end
        end
    endtask

    task automatic fill_const(input lane_t val);
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                cur_st[x][y] = val;
            end
        end
    endtask

    lane_t held [5][5];

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        state_in     = '0;
        exp_valid    = 1'b0;
        fill_const(64'd0);
        exp_st = cur_st;
        #2;

        // Reset wins over in_valid with arbitrary input data.
        fill_random();
        step(1'b1, 1'b1, "reset");
        step(1'b1, 1'b1, "reset2");
        check("reset_lane00_zero", state_out[0][0], 64'd0);
        check("reset_valid_zero", {63'd0, out_valid}, 64'd0);
        step(1'b0, 1'b0, "post_reset_idle");
        step(1'b0, 1'b0, "post_reset_idle2");

        // A single set bit in lane [1][0].
        fill_const(64'd0);
        cur_st[1][0] = 64'h0000_0000_0000_0001;
        step(1'b0, 1'b1, "single_bit");
        check("single_out10", state_out[1][0], 64'h1);
        check("single_out40_wrap", state_out[4][0], 64'h1);
        check("single_out00", state_out[0][0], 64'h0);
        check("single_valid", {63'd0, out_valid}, 64'd1);

        // When every lane is 1, the output equals the input.
        fill_const(64'h0000_0000_0000_0001);
        step(1'b0, 1'b1, "all_ones_lane");
        check("all1_out23", state_out[2][3], 64'h1);
        check("all1_out40", state_out[4][0], 64'h1);

        // Sequential pattern in[x][y] = 5x+y.
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                cur_st[x][y] = lane_t'(5 * x + y);
            end
        end
        step(1'b0, 1'b1, "sequential");
        check("seq_out00", state_out[0][0], 64'hA);
        check("seq_out10", state_out[1][0], 64'h0);
        check("seq_out20", state_out[2][0], 64'h1A);

        // Three states back to back, then two idle cycles that hold the result.
        fill_random();
        step(1'b0, 1'b1, "stream0");
        fill_random();
        step(1'b0, 1'b1, "stream1");
        fill_random();
        step(1'b0, 1'b1, "stream2");
        held = exp_st;
        fill_random();
        step(1'b0, 1'b0, "hold0");
        fill_random();
        step(1'b0, 1'b0, "hold1");
        check("hold_lane34", state_out[3][4], held[3][4]);
        check("hold_valid_low", {63'd0, out_valid}, 64'd0);

        // Random regression with random in_valid and occasional resets.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(3) == 0) begin
                for (int x = 0; x < 5; x++) begin
                    for (int y = 0; y < 5; y++) begin
                        cur_st[x][y] = {$urandom(), $urandom()} & {$urandom(), $urandom()};
                    end
                end
            end else begin
                fill_random();
            end
            step(($urandom_range(99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
